// File: rtl/wb_load_unit.sv
// Writeback stage: forwards ALU results to the register file and holds the core
// on loads until memory data arrives (fixed latency or rvalid handshake).
module wb_load_unit #(
   parameter  int XLEN         = 32,
   parameter  int REG_AW       = 5,
   parameter  int LOAD_LATENCY = 1,
   parameter  int TIMEOUT      = 16,
   localparam int LANE_W       = $clog2(XLEN / 8)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic              ex_mem_ena,
   input  logic              ex_mem_rw,
   input  logic [1:0]        ex_mem_size,
   input  logic              ex_mem_unsigned,
   input  logic [LANE_W-1:0] ex_addr_lo,
   input  logic [REG_AW-1:0] gprs_waddr_i,
   input  logic [XLEN-1:0]   gprs_wdata_i,
   input  logic [XLEN-1:0]   mem_rdata_i,
   input  logic              mem_rvalid_i,
   output logic [REG_AW-1:0] gprs_waddr_o,
   output logic [XLEN-1:0]   gprs_wdata_o,
   output logic              stall,
   output logic [REG_AW-1:0] pend_waddr_o,
   output logic              load_misalign_o,
   output logic              bus_error_o,
   output logic              dbg_state_o
);

   localparam logic MEM_READ = 1'b0;
   localparam int   CNT_MAX  = (LOAD_LATENCY > TIMEOUT) ? LOAD_LATENCY : TIMEOUT;
   localparam int   CNT_W    = $clog2(CNT_MAX + 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [LANE_W-1:0] addr_q, addr_d;

   logic              misalign;
   logic [63:0]       lane64;
   logic [63:0]       ext64;
   logic [XLEN-1:0]   ext_data;
   logic [31:0]       wait_n;
   logic              data_hit;
   logic              tmo_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rd_q    <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
      end
   end

   // A dword access only exists on a 64-bit datapath.
   always_comb begin
      misalign = 1'b0;
      unique case (ex_mem_size)
         2'b00:   misalign = 1'b0;
         2'b01:   misalign = ex_addr_lo[0];
         2'b10:   misalign = (ex_addr_lo[1:0] != 2'b00);
         default: misalign = (XLEN == 64) ? (ex_addr_lo != '0) : 1'b1;
      endcase
   end

   always_comb begin
      lane64 = 64'(mem_rdata_i) >> {addr_q, 3'b000};
      ext64  = lane64;
      unique case (size_q)
         2'b00:   ext64 = uns_q ? {56'b0, lane64[7:0]}  : {{56{lane64[7]}},  lane64[7:0]};
         2'b01:   ext64 = uns_q ? {48'b0, lane64[15:0]} : {{48{lane64[15]}}, lane64[15:0]};
         2'b10:   ext64 = uns_q ? {32'b0, lane64[31:0]} : {{32{lane64[31]}}, lane64[31:0]};
         default: ext64 = lane64;
      endcase
      ext_data = XLEN'(ext64);
   end

   // wait_n counts WAIT cycles including the current one.
   always_comb begin
      wait_n = 32'(cnt_q) + 32'd1;
      if (LOAD_LATENCY > 0) begin
         data_hit = (wait_n == 32'(LOAD_LATENCY));
         tmo_hit  = 1'b0;
      end else begin
         data_hit = mem_rvalid_i;
         tmo_hit  = (wait_n >= 32'(TIMEOUT));
      end
   end

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      rd_d            = rd_q;
      size_d          = size_q;
      uns_d           = uns_q;
      addr_d          = addr_q;
      gprs_waddr_o    = '0;
      gprs_wdata_o    = '0;
      stall           = 1'b0;
      pend_waddr_o    = '0;
      load_misalign_o = 1'b0;
      bus_error_o     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (ex_valid) begin
               if (!ex_mem_ena) begin
                  gprs_waddr_o = gprs_waddr_i;
                  gprs_wdata_o = gprs_wdata_i;
               end else if (ex_mem_rw == MEM_READ) begin
                  if (misalign) begin
                     load_misalign_o = 1'b1;
                  end else begin
                     stall   = 1'b1;
                     rd_d    = gprs_waddr_i;
                     size_d  = ex_mem_size;
                     uns_d   = ex_mem_unsigned;
                     addr_d  = ex_addr_lo;
                     cnt_d   = '0;
                     state_d = S_WAIT;
                  end
               end
            end
         end
         S_WAIT: begin
            pend_waddr_o = rd_q;
            cnt_d        = cnt_q + CNT_W'(1);
            // Data beats the timeout when both land in the same cycle.
            if (data_hit) begin
               if (rd_q != '0) begin
                  gprs_waddr_o = rd_q;
                  gprs_wdata_o = ext_data;
               end
               cnt_d   = '0;
               state_d = S_IDLE;
            end else if (tmo_hit) begin
               bus_error_o = 1'b1;
               cnt_d       = '0;
               state_d     = S_IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (rst) begin
         gprs_waddr_o    = '0;
         gprs_wdata_o    = '0;
         stall           = 1'b0;
         pend_waddr_o    = '0;
         load_misalign_o = 1'b0;
         bus_error_o     = 1'b0;
      end
   end

   assign dbg_state_o = state_q;

endmodule
